// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-channel arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_t;

    // Wide enough for any byte-enable width; users slice the low BE_WIDTH bits.
    localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory request; flags the cycle on which
// the count would reach MAX_WAIT so the arbiter can abort on that edge.
module mem_arb_timer #(
    parameter int MAX_WAIT   = 16,
    parameter int WAIT_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_WIDTH'(1);
        end
    end

    assign expired = enable && (count == WAIT_WIDTH'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory channel between instruction fetch and the
// data cache. Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int MAX_WAIT   = 16,
    parameter int WAIT_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IReq,
    input  logic [DATA_WIDTH-1:0] IA,
    output logic [DATA_WIDTH-1:0] IRD,
    output logic                  IAck,
    input  logic                  DReq,
    input  logic                  DWE,
    input  logic [BE_WIDTH-1:0]   DBE,
    input  logic [DATA_WIDTH-1:0] DA,
    input  logic [DATA_WIDTH-1:0] DWD,
    output logic [DATA_WIDTH-1:0] DRD,
    output logic                  DAck,
    output logic                  MReq,
    output logic                  MWE,
    output logic [BE_WIDTH-1:0]   MBE,
    output logic [DATA_WIDTH-1:0] MA,
    output logic [DATA_WIDTH-1:0] MWD,
    input  logic                  MAck,
    input  logic [DATA_WIDTH-1:0] MRD,
    output logic                  StallI,
    output logic                  StallD,
    output logic                  ErrTimeout
);

    state_t state, state_next;
    req_t   owner;
    logic   serving, done, abort, expired;
    logic   grant_i, grant_d;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign serving  = (state == SERVE_I) || (state == SERVE_D);
    assign done     = serving && MAck;
    assign abort    = serving && !MAck && expired;
    assign rsp_data = (abort || MWE) ? '0 : MRD;

    mem_arb_timer #(
        .MAX_WAIT   (MAX_WAIT),
        .WAIT_WIDTH (WAIT_WIDTH)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .clear   (!serving),
        .enable  (serving && !MAck),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                // owner still names the last requester served while idle
                if (DReq && IReq) begin
                    if (owner == REQ_D) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (DReq) begin
                    grant_d = 1'b1;
                end else if (IReq) begin
                    grant_i = 1'b1;
                end
`else
                if (DReq) begin
                    grant_d = 1'b1;
                end else if (IReq) begin
                    grant_i = 1'b1;
                end
`endif
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done || abort) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        MReq   = serving;
        IAck   = (state == RESP) && (owner == REQ_I);
        DAck   = (state == RESP) && (owner == REQ_D);
        StallI = IReq && !IAck;
        StallD = DReq && !DAck;
    end

    // Memory-side command registers stay frozen from grant until the next grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MWE        <= 1'b0;
            MBE        <= '0;
            MA         <= '0;
            MWD        <= '0;
            IRD        <= '0;
            DRD        <= '0;
            ErrTimeout <= 1'b0;
            owner      <= REQ_D;
        end else begin
            if (grant_d) begin
                MWE   <= DWE;
                MBE   <= DBE;
                MA    <= DA;
                MWD   <= DWD;
                owner <= REQ_D;
            end else if (grant_i) begin
                MWE   <= 1'b0;
                MBE   <= BE_ALL[BE_WIDTH-1:0];
                MA    <= IA;
                MWD   <= '0;
                owner <= REQ_I;
            end
            if (done || abort) begin
                if (owner == REQ_I) begin
                    IRD <= rsp_data;
                end else begin
                    DRD <= rsp_data;
                end
            end
            if (abort) begin
                ErrTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard, with a
// latency-programmable memory responder and hand sequences for reset and back-to-back.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        IReq;
    logic [31:0] IA;
    logic [31:0] IRD;
    logic        IAck;
    logic        DReq;
    logic        DWE;
    logic [3:0]  DBE;
    logic [31:0] DA;
    logic [31:0] DWD;
    logic [31:0] DRD;
    logic        DAck;
    logic        MReq;
    logic        MWE;
    logic [3:0]  MBE;
    logic [31:0] MA;
    logic [31:0] MWD;
    logic        MAck;
    logic [31:0] MRD;
    logic        StallI;
    logic        StallD;
    logic        ErrTimeout;

    mem_arbiter #(
        .DATA_WIDTH (32),
        .BE_WIDTH   (4),
        .MAX_WAIT   (16),
        .WAIT_WIDTH (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IReq       (IReq),
        .IA         (IA),
        .IRD        (IRD),
        .IAck       (IAck),
        .DReq       (DReq),
        .DWE        (DWE),
        .DBE        (DBE),
        .DA         (DA),
        .DWD        (DWD),
        .DRD        (DRD),
        .DAck       (DAck),
        .MReq       (MReq),
        .MWE        (MWE),
        .MBE        (MBE),
        .MA         (MA),
        .MWD        (MWD),
        .MAck       (MAck),
        .MRD        (MRD),
        .StallI     (StallI),
        .StallD     (StallD),
        .ErrTimeout (ErrTimeout)
    );

    typedef struct {
        bit          i_req;
        logic [31:0] ia;
        bit          d_req;
        bit          d_we;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        int          lat;
        logic [31:0] exp_ird;
        logic [31:0] exp_drd;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          is_i;
        logic [31:0] rd;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        mwe;
        logic [3:0]  mbe;
        int          run;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int          applied = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          run = 0;
    int          rise_cyc = 0;
    int          i_ack_cyc = 0;
    int          d_ack_cyc = 0;
    bit          prev_mreq = 0;
    bit          tb_last_d = 1;
    logic [31:0] last_ird = '0;
    logic [31:0] last_drd = '0;
    logic [31:0] snap_ma;
    logic [31:0] snap_mwd;
    logic        snap_mwe;
    logic [3:0]  snap_mbe;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memModel(input logic [31:0] addr);
        if (addr == 32'h0000_0040) begin
            return 32'h0051_3093;
        end
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    // Memory responder: MAck in the lat-th cycle of an MReq run; lat 0 never acks.
    initial begin
        int mcnt;
        mcnt = 0;
        MAck = 1'b0;
        MRD  = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (MReq) begin
                mcnt++;
                if (mem_lat != 0 && mcnt == mem_lat) begin
                    MAck = 1'b1;
                    MRD  = memModel(MA);
                end else begin
                    MAck = 1'b0;
                end
            end else begin
                mcnt = 0;
                MAck = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: tracks memory-side runs and pops the scoreboard on every Ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_mreq = 1'b0;
            end else begin
                if (MReq) begin
                    if (prev_mreq) begin
                        checkOutput("hold_ma", MA, snap_ma);
                        checkOutput("hold_ctl", 32'({MWE, MBE}), 32'({snap_mwe, snap_mbe}));
                        checkOutput("hold_mwd", MWD, snap_mwd);
                        run++;
                    end else begin
                        run = 1;
                        rise_cyc = cyc;
                    end
                    snap_ma  = MA;
                    snap_mwd = MWD;
                    snap_mwe = MWE;
                    snap_mbe = MBE;
                end
                prev_mreq = MReq;
                if (IAck || DAck) begin
                    checkOutput("single_ack", 32'(IAck & DAck), 32'd0);
                    checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        checkOutput("ack_side", 32'(IAck), 32'(e.is_i));
                        if (e.is_i) begin
                            checkOutput("ird", IRD, e.rd);
                            checkOutput("drd_hold", DRD, last_drd);
                            last_ird  = e.rd;
                            i_ack_cyc = cyc;
                        end else begin
                            checkOutput("drd", DRD, e.rd);
                            checkOutput("ird_hold", IRD, last_ird);
                            last_drd  = e.rd;
                            d_ack_cyc = cyc;
                        end
                        checkOutput("ma", snap_ma, e.ma);
                        checkOutput("mwe", 32'(snap_mwe), 32'(e.mwe));
                        checkOutput("mbe", 32'(snap_mbe), 32'(e.mbe));
                        if (e.mwe) begin
                            checkOutput("mwd", snap_mwd, e.mwd);
                        end
                        checkOutput("mreq_cycles", 32'(run), 32'(e.run));
                    end
                end
            end
        end
    end

    // Holds each request until its Ack cycle, then drops it on the following cycle.
    task automatic waitAcks(input bit want_i, input bit want_d);
        bit i_pend;
        bit d_pend;
        bit i_drop;
        bit d_drop;
        int c;
        i_pend = want_i;
        d_pend = want_d;
        i_drop = 1'b0;
        d_drop = 1'b0;
        c = 0;
        while ((i_pend || d_pend) && c < 80) begin
            @(posedge CLK);
            #1;
            c++;
            if (i_drop) begin
                IReq = 1'b0;
                i_drop = 1'b0;
            end
            if (d_drop) begin
                DReq = 1'b0;
                d_drop = 1'b0;
            end
            if (i_pend) begin
                if (IAck) begin
                    checkOutput("stall_i_ack", 32'(StallI), 32'd0);
                    i_pend = 1'b0;
                    i_drop = 1'b1;
                end else begin
                    checkOutput("stall_i_wait", 32'(StallI), 32'd1);
                end
            end
            if (d_pend) begin
                if (DAck) begin
                    checkOutput("stall_d_ack", 32'(StallD), 32'd0);
                    d_pend = 1'b0;
                    d_drop = 1'b1;
                end else begin
                    checkOutput("stall_d_wait", 32'(StallD), 32'd1);
                end
            end
        end
        checkOutput("ack_timeout", 32'(i_pend || d_pend), 32'd0);
        @(posedge CLK);
        #1;
        if (want_i) IReq = 1'b0;
        if (want_d) DReq = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t ei;
        exp_t ed;
        bit   first_i;
        int   gap;
        ei.is_i = 1'b1;
        ei.rd   = v.exp_ird;
        ei.ma   = v.ia;
        ei.mwd  = '0;
        ei.mwe  = 1'b0;
        ei.mbe  = 4'hF;
        ei.run  = (v.lat == 0) ? 16 : v.lat;
        ed.is_i = 1'b0;
        ed.rd   = v.exp_drd;
        ed.ma   = v.da;
        ed.mwd  = v.dwd;
        ed.mwe  = v.d_we;
        ed.mbe  = v.dbe;
        ed.run  = ei.run;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first_i = tb_last_d;
`else
        first_i = 1'b0;
`endif
        if (v.i_req && v.d_req) begin
            if (first_i) begin
                sb.push_back(ei);
                sb.push_back(ed);
                tb_last_d = 1'b1;
            end else begin
                sb.push_back(ed);
                sb.push_back(ei);
                tb_last_d = 1'b0;
            end
        end else if (v.d_req) begin
            sb.push_back(ed);
            tb_last_d = 1'b1;
        end else if (v.i_req) begin
            sb.push_back(ei);
            tb_last_d = 1'b0;
        end
        mem_lat = v.lat;
        IReq = v.i_req;
        IA   = v.ia;
        DReq = v.d_req;
        DWE  = v.d_we;
        DBE  = v.dbe;
        DA   = v.da;
        DWD  = v.dwd;
        waitAcks(v.i_req, v.d_req);
        checkOutput("err_timeout", 32'(ErrTimeout), 32'(v.exp_err));
        if (v.i_req && v.d_req) begin
            gap = first_i ? (d_ack_cyc - i_ack_cyc) : (i_ack_cyc - d_ack_cyc);
            checkOutput("conflict_gap", 32'(gap), 32'(v.lat + 2));
        end
    endtask

    initial begin
        exp_t e;
        int   c;
        int   resp_cyc;

        //         i_req ia            d_req we  dbe      da             dwd            lat ird            drd            err
        vecs[0] = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 4'h0,    32'h0,         32'h0,         2, 32'h0051_3093, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'b0011, 32'h0001_0004, 32'hAABB_CCDD, 1, 32'h0,         32'h0,         1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF,    32'h0000_2000, 32'h0,         3, 32'h0,         32'hDEAD_9EEF, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 4'hF,    32'h0000_3000, 32'h1234_5678, 1, 32'hDEAD_BFEF, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 4'hF,    32'h0000_2000, 32'h0,         1, 32'h0051_3093, 32'hDEAD_9EEF, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF,    32'h0000_4000, 32'h0,         0, 32'h0,         32'h0,         1'b1};
        vecs[6] = '{1'b1, 32'h0000_0800, 1'b0, 1'b0, 4'h0,    32'h0,         32'h0,         1, 32'hDEAD_B6EF, 32'h0,         1'b1};

        RST  = 1'b1;
        IReq = 1'b0;
        IA   = '0;
        DReq = 1'b0;
        DWE  = 1'b0;
        DBE  = '0;
        DA   = '0;
        DWD  = '0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_mreq", 32'(MReq), 32'd0);
        checkOutput("rst_acks", 32'({IAck, DAck}), 32'd0);
        checkOutput("rst_err", 32'(ErrTimeout), 32'd0);
        checkOutput("rst_ma", MA, 32'd0);
        checkOutput("rst_ird", IRD, 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset while a data read is outstanding and memory never answers.
        mem_lat = 0;
        DReq = 1'b1;
        DWE  = 1'b0;
        DBE  = 4'hF;
        DA   = 32'h0000_5000;
        c = 0;
        while (!MReq && c < 10) begin
            @(posedge CLK);
            #1;
            c++;
        end
        checkOutput("rst_test_mreq_seen", 32'(MReq), 32'd1);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("midrst_mreq", 32'(MReq), 32'd0);
        checkOutput("midrst_dack", 32'(DAck), 32'd0);
        checkOutput("midrst_err", 32'(ErrTimeout), 32'd0);
        checkOutput("midrst_ird", IRD, 32'd0);
        sb.delete();
        last_ird  = '0;
        last_drd  = '0;
        tb_last_d = 1'b1;
        @(posedge CLK);
        #1;
        mem_lat = 2;
        e.is_i = 1'b0;
        e.rd   = 32'hDEAD_EEEF;
        e.ma   = 32'h0000_5000;
        e.mwd  = '0;
        e.mwe  = 1'b0;
        e.mbe  = 4'hF;
        e.run  = 2;
        sb.push_back(e);
        RST = 1'b0;
        waitAcks(1'b0, 1'b1);
        checkOutput("post_rst_err", 32'(ErrTimeout), 32'd0);

        // Back-to-back: DReq stays high through DAck and a new address appears in RESP.
        mem_lat = 1;
        e.rd  = 32'hDEAD_9EEF;
        e.ma  = 32'h0000_2000;
        e.run = 1;
        sb.push_back(e);
        DReq = 1'b1;
        DWE  = 1'b0;
        DBE  = 4'hF;
        DA   = 32'h0000_2000;
        c = 0;
        while (!DAck && c < 20) begin
            @(posedge CLK);
            #1;
            c++;
        end
        checkOutput("b2b_first_ack", 32'(DAck), 32'd1);
        resp_cyc = cyc;
        DA   = 32'h0000_0800;
        e.rd = 32'hDEAD_B6EF;
        e.ma = 32'h0000_0800;
        sb.push_back(e);
        waitAcks(1'b0, 1'b1);
        checkOutput("b2b_restart_cycle", 32'(rise_cyc), 32'(resp_cyc + 2));

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
